encoder4x2_stream: RTL and testbench

ENCODER4X2_STREAM -- requirements
Module: encoder4x2_stream

---
 rtl/encoder_pkg.sv | 22 ++
 rtl/bit_pick.sv | 29 ++
 rtl/encoder4x2_stream.sv | 89 ++++++++
 tb/tb_encoder4x2_stream.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared types and widths for the 4-to-2 streaming encoder.
package encoder_pkg;

    localparam int DATA_W = 4;
    localparam int IDX_W  = 2;
    localparam int CNT_W  = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    function automatic logic [CNT_W-1:0] popcount(input logic [DATA_W-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int k = 0; k < DATA_W; k++) begin
            c = c + CNT_W'(v[k]);
        end
        return c;
    endfunction

endpackage

// File: rtl/bit_pick.sv
// Combinational finder for the lowest (or highest) set bit of a 4-bit mask.
module bit_pick
    import encoder_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic [DATA_W-1:0] mask,
    output logic [IDX_W-1:0]  idx,
    output logic              one_hot,
    output logic              zero
);

    always_comb begin
        idx = '0;
        // Scan towards the preferred end so the last hit wins.
        if (LOW_FIRST) begin
            for (int k = DATA_W - 1; k >= 0; k--) begin
                if (mask[k]) idx = IDX_W'(k);
            end
        end else begin
            for (int k = 0; k < DATA_W; k++) begin
                if (mask[k]) idx = IDX_W'(k);
            end
        end
        one_hot = (popcount(mask) == CNT_W'(1));
        zero    = (mask == '0);
    end

endmodule

// File: rtl/encoder4x2_stream.sv
// Accepts a 4-bit request vector and streams the index of each set bit, one beat per handshake.
//   state | meaning
//   IDLE  | ready for a new vector, no beat on the output
//   EMIT  | streaming indices of the pending mask
module encoder4x2_stream
    import encoder_pkg::*;
#(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] d,
    input  logic              d_valid,
    output logic              d_ready,
    output logic [IDX_W-1:0]  i,
    output logic              i_valid,
    input  logic              i_ready,
    output logic              i_last,
    output logic              i_none,
    output logic [CNT_W-1:0]  i_count
);

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  pending_q, pending_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_one;
    logic               pick_zero;

    bit_pick #(.LOW_FIRST(LOW_FIRST)) u_pick (
        .mask    (pending_q),
        .idx     (pick_idx),
        .one_hot (pick_one),
        .zero    (pick_zero)
    );

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        count_d   = count_q;
        d_ready   = 1'b0;
        i_valid   = 1'b0;
        i         = '0;
        i_last    = 1'b0;
        i_none    = 1'b0;
        i_count   = '0;
        case (state_q)
            IDLE: begin
                d_ready = !rst;
                if (d_valid) begin
                    pending_d = d;
                    count_d   = popcount(d);
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                // An all-zero pending mask in EMIT only arises from an accepted zero vector.
                if (!rst) begin
                    i_valid = 1'b1;
                    i       = pick_idx;
                    i_none  = pick_zero;
                    i_last  = pick_one || pick_zero;
                    i_count = count_q;
                    if (i_ready) begin
                        pending_d = pending_q & ~(DATA_W'(1) << pick_idx);
                        if (i_last) begin
                            state_d = IDLE;
                            count_d = '0;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

endmodule

// File: tb/tb_encoder4x2_stream.sv
// Directed bench for encoder4x2_stream; a low-first and a high-first instance share the stimulus.
module tb_encoder4x2_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] d;
    logic       d_valid;
    logic       i_ready;

    logic       lo_d_ready, lo_i_valid, lo_i_last, lo_i_none;
    logic [1:0] lo_i;
    logic [2:0] lo_i_count;
    logic       hi_d_ready, hi_i_valid, hi_i_last, hi_i_none;
    logic [1:0] hi_i;
    logic [2:0] hi_i_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    encoder4x2_stream #(.LOW_FIRST(1'b1)) dut_lo (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(lo_d_ready),
        .i(lo_i), .i_valid(lo_i_valid), .i_ready(i_ready), .i_last(lo_i_last),
        .i_none(lo_i_none), .i_count(lo_i_count)
    );

    encoder4x2_stream #(.LOW_FIRST(1'b0)) dut_hi (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(hi_d_ready),
        .i(hi_i), .i_valid(hi_i_valid), .i_ready(i_ready), .i_last(hi_i_last),
        .i_none(hi_i_none), .i_count(hi_i_count)
    );

    // Advance to the next negative edge; inputs change here and outputs are sampled 1 ns later.
    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; d = 4'b0000; d_valid = 1'b1; i_ready = 1'b1;
        repeat (3) next_cycle();
        #1;
        checks++; if (lo_d_ready !== 1'b0) begin errors++; $display("FAIL reset_d_ready got %b want 0", lo_d_ready); end
        checks++; if (lo_i_valid !== 1'b0) begin errors++; $display("FAIL reset_i_valid got %b want 0", lo_i_valid); end
        checks++; if ({lo_i, lo_i_last, lo_i_none, lo_i_count} !== 7'd0) begin errors++; $display("FAIL reset_outputs got %b want 0", {lo_i, lo_i_last, lo_i_none, lo_i_count}); end
        next_cycle();
        rst = 1'b0; d_valid = 1'b0;
        #1;
        checks++; if (lo_d_ready !== 1'b1 || hi_d_ready !== 1'b1) begin errors++; $display("FAIL release_d_ready got %b%b want 11", lo_d_ready, hi_d_ready); end
        checks++; if (lo_i_valid !== 1'b0) begin errors++; $display("FAIL release_i_valid got %b want 0", lo_i_valid); end
    endtask

    task automatic test_low_first();
        next_cycle();
        d = 4'b1010; d_valid = 1'b1; i_ready = 1'b1;
        next_cycle();
        d_valid = 1'b0; #1;
        checks++; if ({lo_i_valid, lo_i, lo_i_last, lo_i_none, lo_i_count} !== {1'b1, 2'b01, 1'b0, 1'b0, 3'd2}) begin errors++; $display("FAIL low_beat0 got v=%b i=%b last=%b none=%b cnt=%0d want v=1 i=01 last=0 none=0 cnt=2", lo_i_valid, lo_i, lo_i_last, lo_i_none, lo_i_count); end
        checks++; if ({hi_i, hi_i_last} !== {2'b11, 1'b0}) begin errors++; $display("FAIL high_1010_beat0 got i=%b last=%b want i=11 last=0", hi_i, hi_i_last); end
        checks++; if (lo_d_ready !== 1'b0) begin errors++; $display("FAIL low_emit_d_ready got %b want 0", lo_d_ready); end
        next_cycle(); #1;
        checks++; if ({lo_i_valid, lo_i, lo_i_last, lo_i_count} !== {1'b1, 2'b11, 1'b1, 3'd2}) begin errors++; $display("FAIL low_beat1 got v=%b i=%b last=%b cnt=%0d want v=1 i=11 last=1 cnt=2", lo_i_valid, lo_i, lo_i_last, lo_i_count); end
        checks++; if ({hi_i, hi_i_last} !== {2'b01, 1'b1}) begin errors++; $display("FAIL high_1010_beat1 got i=%b last=%b want i=01 last=1", hi_i, hi_i_last); end
        next_cycle(); #1;
        checks++; if ({lo_i_valid, lo_d_ready} !== 2'b01) begin errors++; $display("FAIL low_done got v=%b rdy=%b want v=0 rdy=1", lo_i_valid, lo_d_ready); end
        checks++; if ({lo_i, lo_i_last, lo_i_none, lo_i_count} !== 7'd0) begin errors++; $display("FAIL low_idle_zero got %b want 0", {lo_i, lo_i_last, lo_i_none, lo_i_count}); end
    endtask

    task automatic test_high_first();
        logic [1:0] exp_hi [4];
        logic [1:0] exp_lo [4];
        exp_hi = '{2'b11, 2'b10, 2'b01, 2'b00};
        exp_lo = '{2'b00, 2'b01, 2'b10, 2'b11};
        d = 4'b1111; d_valid = 1'b1; i_ready = 1'b1;
        next_cycle();
        d_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if ({hi_i_valid, hi_i, hi_i_last, hi_i_count} !== {1'b1, exp_hi[k], (k == 3), 3'd4}) begin errors++; $display("FAIL high_beat%0d got v=%b i=%b last=%b cnt=%0d want v=1 i=%b last=%0d cnt=4", k, hi_i_valid, hi_i, hi_i_last, hi_i_count, exp_hi[k], (k == 3)); end
            checks++; if (lo_i !== exp_lo[k]) begin errors++; $display("FAIL low_1111_beat%0d got %b want %b", k, lo_i, exp_lo[k]); end
            next_cycle();
        end
        #1;
        checks++; if ({hi_i_valid, hi_d_ready} !== 2'b01) begin errors++; $display("FAIL high_done got v=%b rdy=%b want v=0 rdy=1", hi_i_valid, hi_d_ready); end
    endtask

    task automatic test_zero();
        d = 4'b0000; d_valid = 1'b1; i_ready = 1'b1;
        next_cycle();
        d_valid = 1'b0; #1;
        checks++; if ({lo_i_valid, lo_i, lo_i_none, lo_i_last, lo_i_count} !== {1'b1, 2'b00, 1'b1, 1'b1, 3'd0}) begin errors++; $display("FAIL zero_beat got v=%b i=%b none=%b last=%b cnt=%0d want v=1 i=00 none=1 last=1 cnt=0", lo_i_valid, lo_i, lo_i_none, lo_i_last, lo_i_count); end
        checks++; if ({hi_i_valid, hi_i_none, hi_i_last} !== 3'b111) begin errors++; $display("FAIL zero_beat_high got %b want 111", {hi_i_valid, hi_i_none, hi_i_last}); end
        next_cycle(); #1;
        checks++; if ({lo_i_valid, lo_d_ready} !== 2'b01) begin errors++; $display("FAIL zero_single got v=%b rdy=%b want v=0 rdy=1", lo_i_valid, lo_d_ready); end
    endtask

    task automatic test_stall();
        d = 4'b0100; d_valid = 1'b1; i_ready = 1'b0;
        next_cycle();
        d_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if ({lo_i_valid, lo_i, lo_i_last, lo_i_none, lo_i_count} !== {1'b1, 2'b10, 1'b1, 1'b0, 3'd1}) begin errors++; $display("FAIL stall_hold%0d got v=%b i=%b last=%b none=%b cnt=%0d want v=1 i=10 last=1 none=0 cnt=1", k, lo_i_valid, lo_i, lo_i_last, lo_i_none, lo_i_count); end
            next_cycle();
        end
        i_ready = 1'b1; #1;
        checks++; if ({lo_i_valid, lo_i} !== {1'b1, 2'b10}) begin errors++; $display("FAIL stall_accept got v=%b i=%b want v=1 i=10", lo_i_valid, lo_i); end
        next_cycle(); #1;
        checks++; if ({lo_i_valid, lo_d_ready} !== 2'b01) begin errors++; $display("FAIL stall_done got v=%b rdy=%b want v=0 rdy=1", lo_i_valid, lo_d_ready); end
    endtask

    task automatic test_reset_mid();
        d = 4'b0110; d_valid = 1'b1; i_ready = 1'b1;
        next_cycle();
        d_valid = 1'b0; #1;
        checks++; if ({lo_i_valid, lo_i} !== {1'b1, 2'b01}) begin errors++; $display("FAIL rstmid_beat0 got v=%b i=%b want v=1 i=01", lo_i_valid, lo_i); end
        next_cycle();
        rst = 1'b1; #1;
        checks++; if ({lo_i_valid, lo_d_ready} !== 2'b00) begin errors++; $display("FAIL rstmid_during got v=%b rdy=%b want v=0 rdy=0", lo_i_valid, lo_d_ready); end
        next_cycle();
        rst = 1'b0; #1;
        checks++; if ({lo_i_valid, lo_d_ready} !== 2'b01) begin errors++; $display("FAIL rstmid_release got v=%b rdy=%b want v=0 rdy=1", lo_i_valid, lo_d_ready); end
        next_cycle(); #1;
        checks++; if (lo_i_valid !== 1'b0 || hi_i_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_beat got %b%b want 00", lo_i_valid, hi_i_valid); end
    endtask

    task automatic test_ignore();
        d = 4'b1001; d_valid = 1'b1; i_ready = 1'b1;
        next_cycle();
        d = 4'b0110; d_valid = 1'b1; #1;
        checks++; if ({lo_d_ready, lo_i, lo_i_count} !== {1'b0, 2'b00, 3'd2}) begin errors++; $display("FAIL ignore_beat0 got rdy=%b i=%b cnt=%0d want rdy=0 i=00 cnt=2", lo_d_ready, lo_i, lo_i_count); end
        next_cycle();
        d = 4'b0010; d_valid = 1'b0; #1;
        checks++; if ({lo_i_valid, lo_i, lo_i_last, lo_i_count} !== {1'b1, 2'b11, 1'b1, 3'd2}) begin errors++; $display("FAIL ignore_beat1 got v=%b i=%b last=%b cnt=%0d want v=1 i=11 last=1 cnt=2", lo_i_valid, lo_i, lo_i_last, lo_i_count); end
        next_cycle(); #1;
        checks++; if ({lo_i_valid, lo_d_ready} !== 2'b01) begin errors++; $display("FAIL ignore_done got v=%b rdy=%b want v=0 rdy=1", lo_i_valid, lo_d_ready); end
        next_cycle(); #1;
        checks++; if (lo_i_valid !== 1'b0) begin errors++; $display("FAIL ignore_no_buffer got %b want 0", lo_i_valid); end
    endtask

    task automatic test_back_to_back();
        d = 4'b0011; d_valid = 1'b1; i_ready = 1'b1;
        next_cycle();
        d = 4'b1000; #1;
        checks++; if ({lo_i, lo_i_last} !== {2'b00, 1'b0}) begin errors++; $display("FAIL b2b_beat0 got i=%b last=%b want i=00 last=0", lo_i, lo_i_last); end
        next_cycle(); #1;
        checks++; if ({lo_i, lo_i_last, lo_d_ready} !== {2'b01, 1'b1, 1'b0}) begin errors++; $display("FAIL b2b_beat1 got i=%b last=%b rdy=%b want i=01 last=1 rdy=0", lo_i, lo_i_last, lo_d_ready); end
        next_cycle(); #1;
        checks++; if ({lo_d_ready, lo_i_valid} !== 2'b10) begin errors++; $display("FAIL b2b_ready got rdy=%b v=%b want rdy=1 v=0", lo_d_ready, lo_i_valid); end
        next_cycle();
        d_valid = 1'b0; #1;
        checks++; if ({lo_i_valid, lo_i, lo_i_last, lo_i_count} !== {1'b1, 2'b11, 1'b1, 3'd1}) begin errors++; $display("FAIL b2b_second got v=%b i=%b last=%b cnt=%0d want v=1 i=11 last=1 cnt=1", lo_i_valid, lo_i, lo_i_last, lo_i_count); end
        next_cycle(); #1;
        checks++; if ({lo_i_valid, lo_d_ready} !== 2'b01) begin errors++; $display("FAIL b2b_done got v=%b rdy=%b want v=0 rdy=1", lo_i_valid, lo_d_ready); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_low_first();
        test_high_first();
        test_zero();
        test_stall();
        test_reset_mid();
        test_ignore();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
